// File: rtl/aes_buf_pkg.sv
// Shared constants and types for the AES output packer (128-bit blocks into 512-bit words).
package aes_buf_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 128;
  localparam int unsigned WORD_W = LANES * LANE_W;

  typedef logic [1:0]       lane_cnt_t;
  typedef logic [LANES-1:0] lane_mask_t;

  // Number of filled lanes (1..4) to a contiguous low-aligned mask.
  function automatic lane_mask_t lanes_to_mask(input logic [2:0] filled);
    lane_mask_t m;
    m = '1;
    case (filled)
      3'd1:    m = 4'b0001;
      3'd2:    m = 4'b0011;
      3'd3:    m = 4'b0111;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/buffer_128_to_512_if.sv
// Block-in / word-out bus of buffer_128_to_512; flush and lane_mask exist only with BUF128_FLUSH_EN.
interface buffer_128_to_512_if;
  import aes_buf_pkg::*;

  logic [LANE_W-1:0] data_in;
  logic              wr_enable;
  logic              in_ready;
  logic [WORD_W-1:0] data_out;
  logic              rd_enable;
  logic              full;
  logic              empty;
  logic              full_n;
  logic              overflow;
`ifdef BUF128_FLUSH_EN
  logic              flush;
  lane_mask_t        lane_mask;

  modport master (
    output data_in, wr_enable, rd_enable, flush,
    input  in_ready, data_out, full, empty, full_n, overflow, lane_mask
  );
  modport slave (
    input  data_in, wr_enable, rd_enable, flush,
    output in_ready, data_out, full, empty, full_n, overflow, lane_mask
  );
`else
  modport master (
    output data_in, wr_enable, rd_enable,
    input  in_ready, data_out, full, empty, full_n, overflow
  );
  modport slave (
    input  data_in, wr_enable, rd_enable,
    output in_ready, data_out, full, empty, full_n, overflow
  );
`endif

endinterface

// File: rtl/sync_fifo_512.sv
// Single-clock FIFO with registered read data and registered level flags; sync active-high reset.
module sync_fifo_512 #(
  parameter int unsigned Width       = 512,
  parameter int unsigned Depth       = 64,
  parameter int unsigned AfullMargin = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             afull
);

  localparam int unsigned      AddrW    = $clog2(Depth);
  localparam logic [AddrW:0]   FullLvl  = (AddrW + 1)'(Depth);
  localparam logic [AddrW:0]   AfullLvl = (AddrW + 1)'(Depth - AfullMargin);
  localparam logic [AddrW:0]   LvlOne   = (AddrW + 1)'(1);
  localparam logic [AddrW-1:0] PtrOne   = AddrW'(1);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wptr_q, rptr_q;
  logic [AddrW:0]   level_q, level_d;
  logic [Width-1:0] rdata_q;
  logic             full_q, empty_q, afull_q;
  logic             push_ok, pop_ok;

  // Gated by registered flags only, so a same-cycle pop never makes room for a push.
  assign push_ok = push & ~full_q;
  assign pop_ok  = pop & ~empty_q;

  always_comb begin
    level_d = level_q;
    unique case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LvlOne;
      2'b01:   level_d = level_q - LvlOne;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      rdata_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      afull_q <= 1'b0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PtrOne;
      if (pop_ok) begin
        rptr_q  <= rptr_q + PtrOne;
        rdata_q <= mem_q[rptr_q];
      end
      level_q <= level_d;
      full_q  <= (level_d == FullLvl);
      empty_q <= (level_d == '0);
      afull_q <= (level_d >= AfullLvl);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wptr_q] <= wdata;
  end

  assign rdata = rdata_q;
  assign full  = full_q;
  assign empty = empty_q;
  assign afull = afull_q;

endmodule

// File: rtl/buffer_128_to_512.sv
// Packs four 128-bit AES blocks (first block in the low lane) into 512-bit words queued in a FIFO.
// Define BUF128_FLUSH_EN to add flush of a partial word and a per-word lane_mask.
module buffer_128_to_512
  import aes_buf_pkg::*;
#(
  parameter int unsigned DEPTH        = 64,
  parameter int unsigned AFULL_MARGIN = 4
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 clr,
  buffer_128_to_512_if.slave  bus
);

  logic                      srst;
  lane_cnt_t                 lane_q, lane_d;
  logic [(LANES-1)*LANE_W-1:0] asm_q, asm_d;
  logic                      overflow_q;
  logic                      in_ready, wr_acc, push, fifo_full, fifo_empty, fifo_afull;
  logic [WORD_W-1:0]         word;

  assign srst     = rst | clr;
  assign in_ready = ~fifo_full;
  assign wr_acc   = bus.wr_enable & in_ready;

  // Lanes not yet written are zero so a flushed partial word carries no stale data.
  always_comb begin
    word = '0;
    for (int unsigned i = 0; i < LANES - 1; i++) begin
      if (i < 32'(lane_q)) word[i*LANE_W +: LANE_W] = asm_q[i*LANE_W +: LANE_W];
    end
    if (wr_acc) word[32'(lane_q)*LANE_W +: LANE_W] = bus.data_in;
  end

`ifdef BUF128_FLUSH_EN
  logic [2:0] filled;
  logic       flush_push;
  lane_mask_t mask;

  assign filled     = {1'b0, lane_q} + {2'b00, wr_acc};
  assign flush_push = bus.flush & in_ready & (filled != 3'd0);
  assign push       = (wr_acc & (lane_q == 2'd3)) | flush_push;
  assign mask       = lanes_to_mask(filled);
`else
  assign push       = wr_acc & (lane_q == 2'd3);
`endif

  always_comb begin
    lane_d = lane_q;
    asm_d  = asm_q;
    if (wr_acc) begin
      lane_d = lane_q + 2'd1;
      if (lane_q != 2'd3) asm_d[32'(lane_q)*LANE_W +: LANE_W] = bus.data_in;
    end
`ifdef BUF128_FLUSH_EN
    if (flush_push) lane_d = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      lane_q     <= '0;
      asm_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      lane_q     <= lane_d;
      asm_q      <= asm_d;
      overflow_q <= overflow_q | (bus.wr_enable & ~in_ready);
    end
  end

`ifdef BUF128_FLUSH_EN
  localparam int unsigned FifoW = WORD_W + LANES;
  logic [FifoW-1:0] fifo_rdata;

  sync_fifo_512 #(
    .Width      (FifoW),
    .Depth      (DEPTH),
    .AfullMargin(AFULL_MARGIN)
  ) u_fifo (
    .clk  (clk),
    .rst  (srst),
    .push (push),
    .wdata({mask, word}),
    .pop  (bus.rd_enable),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty),
    .afull(fifo_afull)
  );

  assign bus.data_out  = fifo_rdata[WORD_W-1:0];
  assign bus.lane_mask = fifo_rdata[FifoW-1:WORD_W];
`else
  logic [WORD_W-1:0] fifo_rdata;

  sync_fifo_512 #(
    .Width      (WORD_W),
    .Depth      (DEPTH),
    .AfullMargin(AFULL_MARGIN)
  ) u_fifo (
    .clk  (clk),
    .rst  (srst),
    .push (push),
    .wdata(word),
    .pop  (bus.rd_enable),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty),
    .afull(fifo_afull)
  );

  assign bus.data_out = fifo_rdata;
`endif

  assign bus.in_ready = in_ready;
  assign bus.full     = fifo_full;
  assign bus.empty    = fifo_empty;
  assign bus.full_n   = fifo_afull;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_buffer_128_to_512.sv
// Bench for buffer_128_to_512: vector table plus queue scoreboard; flush cases with BUF128_FLUSH_EN.
module tb_buffer_128_to_512;
  import aes_buf_pkg::*;

  localparam int unsigned DEPTH        = 64;
  localparam int unsigned AFULL_MARGIN = 4;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  always #5 clk = ~clk;

  buffer_128_to_512_if bus();

  buffer_128_to_512 #(
    .DEPTH       (DEPTH),
    .AFULL_MARGIN(AFULL_MARGIN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [WORD_W-1:0] sb_word[$];
  logic [LANES-1:0]  sb_mask[$];
  logic [LANE_W-1:0] m_asm [LANES];
  int                m_lane;
  logic [WORD_W-1:0] m_dout;
  logic [LANES-1:0]  m_mask;
  logic              m_ovf;

  typedef struct {
    logic              r;
    logic              c;
    logic              wr;
    logic [LANE_W-1:0] d;
    logic              rd;
    logic              exp_empty;
    logic              chk_d;
    logic [WORD_W-1:0] exp_d;
  } vec_t;

  vec_t tbl[$];

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_word(input string name, input logic [WORD_W-1:0] act,
                          input logic [WORD_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [LANE_W-1:0] lv(input logic [7:0] tag, input int i);
    return {4{tag, i[23:0]}};
  endfunction

  function automatic logic [LANE_W-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic vec_t mk(input logic r, input logic c, input logic wr,
                              input logic [LANE_W-1:0] d, input logic rd, input logic ee,
                              input logic chkd, input logic [WORD_W-1:0] ed);
    vec_t v;
    v.r = r; v.c = c; v.wr = wr; v.d = d; v.rd = rd;
    v.exp_empty = ee; v.chk_d = chkd; v.exp_d = ed;
    return v;
  endfunction

  task automatic m_reset();
    sb_word.delete();
    sb_mask.delete();
    m_lane = 0;
    m_dout = '0;
    m_mask = '0;
    m_ovf  = 1'b0;
    for (int i = 0; i < LANES; i++) m_asm[i] = '0;
  endtask

  // One clock: drive inputs, advance the model, then compare all outputs after the edge.
  task automatic step(input logic r, input logic c, input logic wr, input logic [LANE_W-1:0] d,
                      input logic rd, input logic fl);
    int                pre;
    logic              ready;
    int                filled;
    logic [WORD_W-1:0] w;
    rst = r;
    clr = c;
    bus.wr_enable = wr;
    bus.data_in   = d;
    bus.rd_enable = rd;
`ifdef BUF128_FLUSH_EN
    bus.flush     = fl;
`endif
    pre   = sb_word.size();
    ready = (pre < int'(DEPTH));
    if (r || c) begin
      m_reset();
    end else begin
      if (rd && pre > 0) begin
        m_dout = sb_word.pop_front();
        m_mask = sb_mask.pop_front();
      end
      if (wr && !ready) m_ovf = 1'b1;
      if (wr && ready) begin
        m_asm[m_lane] = d;
        filled = m_lane + 1;
      end else begin
        filled = m_lane;
      end
      if ((wr && ready && m_lane == 3) || (fl && ready && filled > 0)) begin
        w = '0;
        for (int i = 0; i < filled; i++) w[i*LANE_W +: LANE_W] = m_asm[i];
        sb_word.push_back(w);
        sb_mask.push_back(LANES'((1 << filled) - 1));
        m_lane = 0;
      end else if (wr && ready) begin
        m_lane = m_lane + 1;
      end
    end
    @(posedge clk);
    #1;
    chk_word("data_out", bus.data_out, m_dout);
    chk_bit("empty", bus.empty, sb_word.size() == 0);
    chk_bit("full", bus.full, sb_word.size() == int'(DEPTH));
    chk_bit("full_n", bus.full_n, sb_word.size() >= int'(DEPTH - AFULL_MARGIN));
    chk_bit("in_ready", bus.in_ready, sb_word.size() < int'(DEPTH));
    chk_bit("overflow", bus.overflow, m_ovf);
`ifdef BUF128_FLUSH_EN
    chk_word("lane_mask", WORD_W'(bus.lane_mask), WORD_W'(m_mask));
`endif
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [WORD_W-1:0] wa, wc, we;
    rst = 1'b1;
    clr = 1'b0;
    bus.wr_enable = 1'b0;
    bus.rd_enable = 1'b0;
    bus.data_in   = '0;
`ifdef BUF128_FLUSH_EN
    bus.flush     = 1'b0;
`endif
    m_reset();

    wa = {lv(8'hA0, 3), lv(8'hA0, 2), lv(8'hA0, 1), lv(8'hA0, 0)};
    wc = {lv(8'hC0, 3), lv(8'hC0, 2), lv(8'hC0, 1), lv(8'hC0, 0)};
    we = {lv(8'hE0, 3), lv(8'hE0, 2), lv(8'hE0, 1), lv(8'hE0, 0)};

    // Basic packing, idle read, reset and clear discarding partial words
    tbl.push_back(mk(1, 0, 0, '0, 0, 1, 1, '0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 1, lv(8'hA0, i), 0, i < 3, 0, '0));
    tbl.push_back(mk(0, 0, 0, '0, 0, 0, 0, '0));
    tbl.push_back(mk(0, 0, 0, '0, 1, 1, 1, wa));
    tbl.push_back(mk(0, 0, 0, '0, 1, 1, 1, wa));
    tbl.push_back(mk(0, 0, 1, lv(8'hB0, 0), 0, 1, 0, '0));
    tbl.push_back(mk(0, 0, 1, lv(8'hB0, 1), 0, 1, 0, '0));
    tbl.push_back(mk(1, 0, 1, lv(8'hB0, 2), 1, 1, 1, '0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 1, lv(8'hC0, i), 0, i < 3, 0, '0));
    tbl.push_back(mk(0, 0, 0, '0, 1, 1, 1, wc));
    tbl.push_back(mk(0, 0, 1, lv(8'hD0, 0), 0, 1, 0, '0));
    tbl.push_back(mk(0, 0, 1, lv(8'hD0, 1), 0, 1, 0, '0));
    tbl.push_back(mk(0, 1, 1, lv(8'hD0, 2), 1, 1, 1, '0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 1, lv(8'hE0, i), 0, i < 3, 0, '0));
    tbl.push_back(mk(0, 0, 0, '0, 1, 1, 1, we));

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].c, tbl[i].wr, tbl[i].d, tbl[i].rd, 1'b0);
      chk_bit("tbl_empty", bus.empty, tbl[i].exp_empty);
      chk_bit("tbl_in_ready", bus.in_ready, 1'b1);
      if (tbl[i].chk_d) chk_word("tbl_data", bus.data_out, tbl[i].exp_d);
    end

    // Fill to DEPTH words, then overflow and same-cycle push/pop at full
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < int'(4 * DEPTH); i++) step(1'b0, 1'b0, 1'b1, rnd(), 1'b0, 1'b0);
    chk_bit("fill_full", bus.full, 1'b1);
    chk_bit("fill_in_ready", bus.in_ready, 1'b0);
    step(1'b0, 1'b0, 1'b1, lv(8'hF0, 0), 1'b0, 1'b0);
    chk_bit("fill_overflow", bus.overflow, 1'b1);
    step(1'b0, 1'b0, 1'b1, lv(8'hF0, 1), 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, lv(8'h60, i), 1'b0, 1'b0);
    drain(DEPTH + 2);

    // Streaming writes with a pop every fourth cycle
    step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int c = 0; c < 1000; c++) step(1'b0, 1'b0, 1'b1, rnd(), (c % 4) == 3, 1'b0);
    chk_bit("stream_no_overflow", bus.overflow, 1'b0);
    drain(4);

    // Random traffic: pointer wrap, then pressure toward full
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int c = 0; c < 400; c++)
      step(1'b0, 1'b0, ($urandom % 4) != 0, rnd(), ($urandom % 3) == 0, 1'b0);
    for (int c = 0; c < 400; c++)
      step(1'b0, 1'b0, ($urandom % 8) != 0, rnd(), ($urandom % 8) == 0, 1'b0);
    drain(DEPTH + 2);

`ifdef BUF128_FLUSH_EN
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, lv(8'h70, 0), 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, lv(8'h70, 1), 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk_word("flush2_data", bus.data_out, {256'd0, lv(8'h70, 1), lv(8'h70, 0)});
    chk_word("flush2_mask", WORD_W'(bus.lane_mask), WORD_W'(4'b0011));
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, lv(8'h80, i), 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, lv(8'h80, 3), 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, lv(8'h90, 0), 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk_word("flush4_mask", WORD_W'(bus.lane_mask), WORD_W'(4'b1111));
    for (int c = 0; c < 200; c++)
      step(1'b0, 1'b0, ($urandom % 2) != 0, rnd(), ($urandom % 3) == 0, ($urandom % 5) == 0);
    drain(DEPTH + 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/buffer_128_to_512.md
BUFFER_128_TO_512 -- requirements
Module: buffer_128_to_512

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning the output FIFO depth in 512-bit words (power of 2, at least 4).
REQ-002 SHALL have parameter AFULL_MARGIN, default 4, meaning full_n asserts when at most this many free entries remain.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port clr, input, 1 bit: synchronous, active-high clear, with the same effect as rst.
REQ-006 SHALL have port data_in, input, 128 bits: one AES output block.
REQ-007 SHALL have port wr_enable, input, 1 bit: data_in is valid this cycle.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts wr_enable this cycle.
REQ-009 SHALL have port data_out, output, 512 bits: the packed word.
REQ-010 SHALL have port rd_enable, input, 1 bit: pop one packed word.
REQ-011 SHALL have port full, output, 1 bit: the FIFO holds DEPTH words.
REQ-012 SHALL have port empty, output, 1 bit: the FIFO holds no complete word.
REQ-013 SHALL have port full_n, output, 1 bit: almost full, meaning the FIFO level is at least DEPTH-AFULL_MARGIN.
REQ-014 SHALL have port overflow, output, 1 bit: sticky flag set when wr_enable arrives while in_ready is 0.

Function
REQ-015 SHALL hold a 2-bit lane counter, values 0..3, that increments on every accepted write and wraps from 3 to 0.
REQ-016 SHALL, on an accepted write with lane count 0..2, store data_in into assembly register bits [lane*128+127 : lane*128].
REQ-017 SHALL, on an accepted write with lane count 3, push {data_in, asm[383:0]} into the FIFO in the same cycle; the first block received lands in bits [127:0].
REQ-018 SHALL drive in_ready = !full, using registered state only; a pop in the same cycle does not free space for that cycle's push.
REQ-019 SHALL ignore a write that arrives while in_ready=0: no lane advance, no storage, and overflow is set on the next edge.
REQ-020 SHALL make empty deassert the cycle after the push that completes a word.
REQ-021 SHALL register the read: rd_enable with empty=0 at edge N presents the word on data_out after edge N, and data_out holds until the next valid pop.
REQ-022 SHALL ignore rd_enable while empty=1: no pointer change, data_out unchanged.
REQ-023 SHALL, on a simultaneous push and pop with 0<level<DEPTH, leave the level unchanged and keep both pointers advancing, wrapping modulo DEPTH.
REQ-024 SHALL produce full, empty and full_n as registered outputs derived from the level counter, which has width $clog2(DEPTH)+1.

Reset
REQ-025 SHALL, on rst or clr, set the following on the next edge: lane counter 0, assembly register 0, FIFO pointers and level 0, data_out 0, overflow 0, empty 1, full 0, full_n 0, in_ready 1.
REQ-026 SHALL discard any partially assembled word (1 to 3 lanes) and all stored words when rst or clr arrives mid-operation.
REQ-027 SHALL give rst and clr priority over simultaneous wr_enable or rd_enable.

Configuration
REQ-028 SHALL, with BUF128_FLUSH_EN defined, add input flush (1 bit) and output lane_mask (4 bits).
REQ-029 SHALL, with BUF128_FLUSH_EN defined, make flush with lane count >0 and in_ready=1 push the partial word with the unfilled lanes zeroed, then reset the lane count to 0.
REQ-030 SHALL, with BUF128_FLUSH_EN defined, store lane_mask alongside each word: 4'hF for a full word, 4'b0001/0011/0111 for a flush with 1/2/3 lanes filled; lane_mask follows data_out with the same latency.
REQ-031 SHALL, with BUF128_FLUSH_EN defined and both flush and wr_enable asserted, include data_in in the pushed word, which becomes full at lane count 3.
REQ-032 SHALL, with BUF128_FLUSH_EN undefined, have no flush port, no lane_mask port, and no mask storage.

Structure
REQ-033 SHALL take the constants LANES=4, LANE_W=128 and WORD_W=512 from shared package aes_buf_pkg.
REQ-034 SHALL define the lane-count typedef and the lane-mask typedef in aes_buf_pkg.
REQ-035 SHALL use exactly one sub-module, sync_fifo_512, a parameterised single-clock FIFO with registered read that uses the same synchronous active-high reset.

Verification
REQ-036 SHALL cover: reset, then 4 writes A0..A3, wait 1 cycle, then rd_enable -> data_out={A3,A2,A1,A0} after that edge, and empty=1 after the pop.
REQ-037 SHALL cover: rst asserted after 2 writes, then 4 writes B0..B3 -> exactly one word {B3,B2,B1,B0}, with no A lanes present.
REQ-038 SHALL cover: fill DEPTH words -> full=1, in_ready=0, full_n=1 from level DEPTH-4; one extra write -> overflow=1 and lane count unchanged.
REQ-039 SHALL cover: continuous writes with rd_enable every 4th cycle -> level stays constant, with no overflow and no dropped words over 1000 cycles.
REQ-040 SHALL cover: rd_enable while empty -> data_out unchanged and level stays 0.
REQ-041 SHALL cover, with BUF128_FLUSH_EN defined: 2 writes C0,C1 then flush -> data_out={0,0,C1,C0}, lane_mask=4'b0011.
